ultrasonic_scan_scheduler: RTL and testbench

Round-robin scheduler that shares one measurement engine across N HC-SR04-style ultrasonic sensors. For each sensor in turn it fires a trigger pulse, times the echo, and converts the echo width to centimetres. It stores one result per sensor and enforces an inter-ping gap so that crosstalk between sensors is avoided. It sits between the sensor pins and the display/control logic.

---
 rtl/ultrasonic_scan_scheduler.sv | 216 +++++++++++++++++++++
 tb/tb_ultrasonic_scan_scheduler.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ultrasonic_scan_scheduler.sv
// -----------------------------------------------------------------------------
// ultrasonic_scan_scheduler
// Round-robin scheduler sharing one echo-timing engine across N HC-SR04-style
// ultrasonic sensors: trigger, time the echo, convert to cm, store per sensor,
// then idle for an inter-ping gap to avoid crosstalk.
//
// Ports:
//   clk           system clock
//   reset_p       synchronous active-high reset
//   enable        scanning runs while high (a started ping always completes)
//   echo[N]       raw asynchronous echo inputs
//   trig[N]       trigger outputs, at most one high
//   dist_flat     latest distance per sensor, sensor i at [9i+8:9i]
//   data_valid    one-cycle pulse when a result is written
//   data_id       sensor index of current / most recent measurement
//   data_timeout  qualifies data_valid: result came from a timeout
//
// Optional build macro TIMEOUT_HOLD_EN: when defined, a timeout leaves the
// stored distance unchanged instead of writing 511.
// -----------------------------------------------------------------------------
module ultrasonic_scan_scheduler #(
    parameter int unsigned N_SENSORS  = 4,
    parameter int unsigned CLK_MHZ    = 125,
    parameter int unsigned TRIG_US    = 10,
    parameter int unsigned TIMEOUT_US = 25000,
    parameter int unsigned GAP_US     = 60000,
    parameter int unsigned US_PER_CM  = 58,
    localparam int unsigned ID_W      = $clog2(N_SENSORS)
) (
    input  logic                   clk,
    input  logic                   reset_p,
    input  logic                   enable,
    input  logic [N_SENSORS-1:0]   echo,
    output logic [N_SENSORS-1:0]   trig,
    output logic [9*N_SENSORS-1:0] dist_flat,
    output logic                   data_valid,
    output logic [ID_W-1:0]        data_id,
    output logic                   data_timeout
);

    localparam int unsigned PRE_W    = $clog2(CLK_MHZ + 1);
    localparam int unsigned MAX_US_A = (TRIG_US > GAP_US) ? TRIG_US : GAP_US;
    localparam int unsigned MAX_US   = (TIMEOUT_US > MAX_US_A) ? TIMEOUT_US : MAX_US_A;
    localparam int unsigned US_W     = $clog2(MAX_US + 1);
    localparam int unsigned SUB_W    = $clog2(US_PER_CM + 1);
    localparam int unsigned CM_W     = 9;
    localparam logic [CM_W-1:0] CM_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIG,
        S_WAIT_RISE,
        S_MEASURE,
        S_GAP
    } state_t;

    state_t                state_q;
    logic [PRE_W-1:0]      pre_q;      // cycles within the current microsecond
    logic [US_W-1:0]       us_q;       // trig width / timeout / gap microseconds
    logic [SUB_W-1:0]      sub_q;      // microseconds within the current cm
    logic [CM_W-1:0]       cm_q;
    logic [ID_W-1:0]       id_q;
    logic [N_SENSORS-1:0]  trig_q;
    logic [CM_W-1:0]       dist_q [N_SENSORS];
    logic                  valid_q;
    logic                  tmo_q;
    logic [N_SENSORS-1:0]  echo_s1_q;
    logic [N_SENSORS-1:0]  echo_s2_q;
    logic [N_SENSORS-1:0]  echo_s3_q;  // previous synchronized value for edge detect

    logic                  tick_c;
    logic                  rise_c;
    logic                  fall_c;
    logic                  done_c;
    logic                  tmo_c;
    logic [ID_W-1:0]       next_id_c;
    logic [N_SENSORS-1:0]  one_c;

    // Tick, echo edges of the selected sensor, and measurement-end events
    always_comb begin
        one_c     = {{(N_SENSORS-1){1'b0}}, 1'b1};
        tick_c    = (pre_q == PRE_W'(CLK_MHZ - 1));
        rise_c    = echo_s2_q[id_q] & ~echo_s3_q[id_q];
        fall_c    = ~echo_s2_q[id_q] & echo_s3_q[id_q];
        done_c    = (state_q == S_MEASURE) && fall_c;
        // An echo fall in the same cycle as the timeout takes priority
        tmo_c     = ((state_q == S_WAIT_RISE) || (state_q == S_MEASURE)) && tick_c
                    && (us_q == US_W'(TIMEOUT_US - 1)) && !done_c;
        next_id_c = (id_q == ID_W'(N_SENSORS - 1)) ? '0 : id_q + 1'b1;
    end

    // Synchronizer, prescaler, counters and scan FSM
    always_ff @(posedge clk) begin
        if (reset_p) begin
            state_q   <= S_IDLE;
            pre_q     <= '0;
            us_q      <= '0;
            sub_q     <= '0;
            cm_q      <= '0;
            id_q      <= '0;
            trig_q    <= '0;
            valid_q   <= 1'b0;
            tmo_q     <= 1'b0;
            echo_s1_q <= '0;
            echo_s2_q <= '0;
            echo_s3_q <= '0;
            for (int i = 0; i < int'(N_SENSORS); i++) begin
                dist_q[i] <= '0;
            end
        end else begin
            echo_s1_q <= echo;
            echo_s2_q <= echo_s1_q;
            echo_s3_q <= echo_s2_q;
            valid_q   <= 1'b0;
            tmo_q     <= 1'b0;
            pre_q     <= tick_c ? '0 : pre_q + 1'b1;

            if (done_c || tmo_c) begin
                state_q <= S_GAP;
                pre_q   <= '0;
                us_q    <= '0;
                valid_q <= 1'b1;
                tmo_q   <= tmo_c;
`ifdef TIMEOUT_HOLD_EN
                if (done_c) begin
                    dist_q[id_q] <= cm_q;
                end
`else
                dist_q[id_q] <= done_c ? cm_q : CM_MAX;
`endif
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (enable) begin
                            state_q <= S_TRIG;
                            trig_q  <= one_c << id_q;
                            pre_q   <= '0;
                            us_q    <= '0;
                        end
                    end
                    S_TRIG: begin
                        if (tick_c) begin
                            if (us_q == US_W'(TRIG_US - 1)) begin
                                state_q <= S_WAIT_RISE;
                                trig_q  <= '0;
                                us_q    <= '0;
                            end else begin
                                us_q <= us_q + 1'b1;
                            end
                        end
                    end
                    S_WAIT_RISE: begin
                        if (tick_c) begin
                            us_q <= us_q + 1'b1;
                        end
                        // Only a low-to-high transition seen here starts a measurement
                        if (rise_c) begin
                            state_q <= S_MEASURE;
                            pre_q   <= '0;
                            sub_q   <= '0;
                            cm_q    <= '0;
                        end
                    end
                    S_MEASURE: begin
                        if (tick_c) begin
                            us_q <= us_q + 1'b1;
                            if (sub_q == SUB_W'(US_PER_CM - 1)) begin
                                sub_q <= '0;
                                if (cm_q != CM_MAX) begin
                                    cm_q <= cm_q + 1'b1;
                                end
                            end else begin
                                sub_q <= sub_q + 1'b1;
                            end
                        end
                    end
                    S_GAP: begin
                        if (tick_c) begin
                            if (us_q == US_W'(GAP_US - 1)) begin
                                id_q  <= next_id_c;
                                us_q  <= '0;
                                pre_q <= '0;
                                if (enable) begin
                                    state_q <= S_TRIG;
                                    trig_q  <= one_c << next_id_c;
                                end else begin
                                    state_q <= S_IDLE;
                                end
                            end else begin
                                us_q <= us_q + 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                        trig_q  <= '0;
                    end
                endcase
            end
        end
    end

    // Flatten per-sensor results onto the output bus
    always_comb begin
        dist_flat = '0;
        for (int i = 0; i < int'(N_SENSORS); i++) begin
            dist_flat[9*i +: 9] = dist_q[i];
        end
    end

    assign trig         = trig_q;
    assign data_valid   = valid_q;
    assign data_id      = id_q;
    assign data_timeout = tmo_q;

endmodule

// File: tb/tb_ultrasonic_scan_scheduler.sv
// -----------------------------------------------------------------------------
// tb_ultrasonic_scan_scheduler
// Directed bench with scaled timing: 2 cycles per us, 10 us trigger, 2200 us
// timeout, 30 us gap, 4 us per cm. Expected values are hand-computed:
// an echo high for H cycles yields floor(floor((H-1)/2)/4) cm.
// -----------------------------------------------------------------------------
module tb_ultrasonic_scan_scheduler;

    localparam int unsigned N       = 4;
    localparam int          TO_CYC  = 4400;
    localparam int          GAP_CYC = 60;
`ifdef TIMEOUT_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset_p;
    logic           enable;
    logic [N-1:0]   echo;
    logic [N-1:0]   trig;
    logic [9*N-1:0] dist_flat;
    logic           data_valid;
    logic [1:0]     data_id;
    logic           data_timeout;

    int n_cmp = 0;
    int n_bad = 0;

    ultrasonic_scan_scheduler #(
        .N_SENSORS(4), .CLK_MHZ(2), .TRIG_US(10), .TIMEOUT_US(2200),
        .GAP_US(30), .US_PER_CM(4)
    ) dut (
        .clk(clk), .reset_p(reset_p), .enable(enable), .echo(echo),
        .trig(trig), .dist_flat(dist_flat), .data_valid(data_valid),
        .data_id(data_id), .data_timeout(data_timeout)
    );

    always #5 clk = ~clk;

    function automatic int dist_of(input int i);
        return int'(dist_flat[9*i +: 9]);
    endfunction

    // Wait until trig[idx] has been seen high and then low
    task automatic wait_trig_pulse(input int idx, input int budget, output bit ok);
        bit seen;
        seen = trig[idx];
        ok   = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(posedge clk); #1;
            if (trig[idx]) seen = 1'b1;
            else if (seen) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_valid(input int budget, output int cyc, output bit ok);
        ok  = 1'b0;
        cyc = 0;
        for (int c = 0; c < budget; c++) begin
            @(posedge clk); #1;
            cyc++;
            if (data_valid) begin ok = 1'b1; break; end
        end
    endtask

    // Fire one echo on sensor idx after its trigger and wait for the result
    task automatic ping(input int idx, input int pre, input int high, output bit ok);
        bit ok1, ok2;
        int lat;
        wait_trig_pulse(idx, 300, ok1);
        repeat (pre) @(negedge clk);
        echo[idx] = 1'b1;
        repeat (high) @(negedge clk);
        echo[idx] = 1'b0;
        wait_valid(20, lat, ok2);
        ok = ok1 & ok2;
    endtask

    task automatic test_reset();
        reset_p = 1'b1; enable = 1'b0; echo = '0;
        repeat (2) @(posedge clk); #1;
        n_cmp++; if (trig !== 4'b0000) begin n_bad++; $display("FAIL reset_trig: got %b expected 0000", trig); end
        n_cmp++; if (dist_flat !== '0) begin n_bad++; $display("FAIL reset_dist: got %h expected 0", dist_flat); end
        n_cmp++; if (data_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b expected 0", data_valid); end
        n_cmp++; if (data_id !== 2'd0) begin n_bad++; $display("FAIL reset_id: got %0d expected 0", data_id); end
        n_cmp++; if (data_timeout !== 1'b0) begin n_bad++; $display("FAIL reset_timeout: got %b expected 0", data_timeout); end
        @(negedge clk); reset_p = 1'b0;
    endtask

    task automatic test_trigger();
        bit found, other;
        int w;
        found = 1'b0; other = 1'b0; w = 0;
        @(negedge clk); enable = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (trig[0]) begin found = 1'b1; break; end
        end
        n_cmp++; if (found !== 1'b1) begin n_bad++; $display("FAIL trig0_start: got %b expected 1", found); end
        w = 1;
        for (int c = 0; c < 2000; c++) begin
            if (trig[3:1] !== 3'b000) other = 1'b1;
            @(posedge clk); #1;
            if (trig[0]) w++; else break;
        end
        n_cmp++; if (w !== 20) begin n_bad++; $display("FAIL trig0_width: got %0d expected 20", w); end
        n_cmp++; if (other !== 1'b0) begin n_bad++; $display("FAIL trig_others: got %b expected 0", other); end
        n_cmp++; if (data_id !== 2'd0) begin n_bad++; $display("FAIL trig0_id: got %0d expected 0", data_id); end
    endtask

    task automatic test_measure();
        bit ok;
        int lat, g;
        repeat (15) @(negedge clk);
        echo[0] = 1'b1;
        repeat (117) @(negedge clk);
        echo[0] = 1'b0;
        wait_valid(20, lat, ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL meas_valid_seen: got %b expected 1", ok); end
        n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL meas_latency: got %0d expected 3", lat); end
        n_cmp++; if (data_id !== 2'd0) begin n_bad++; $display("FAIL meas_id: got %0d expected 0", data_id); end
        n_cmp++; if (data_timeout !== 1'b0) begin n_bad++; $display("FAIL meas_timeout: got %b expected 0", data_timeout); end
        n_cmp++; if (dist_of(0) !== 14) begin n_bad++; $display("FAIL meas_dist0: got %0d expected 14", dist_of(0)); end
        @(posedge clk); #1;
        n_cmp++; if (data_valid !== 1'b0) begin n_bad++; $display("FAIL valid_pulse: got %b expected 0", data_valid); end
        g = 1;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk); #1;
            g++;
            if (trig[1]) break;
        end
        n_cmp++; if (g !== GAP_CYC) begin n_bad++; $display("FAIL gap_len: got %0d expected %0d", g, GAP_CYC); end
    endtask

    task automatic test_timeout();
        bit ok;
        int cyc;
        wait_trig_pulse(1, 100, ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL to1_trig: got %b expected 1", ok); end
        wait_valid(5000, cyc, ok);
        n_cmp++; if (cyc !== TO_CYC) begin n_bad++; $display("FAIL to1_cycles: got %0d expected %0d", cyc, TO_CYC); end
        n_cmp++; if (data_id !== 2'd1) begin n_bad++; $display("FAIL to1_id: got %0d expected 1", data_id); end
        n_cmp++; if (data_timeout !== 1'b1) begin n_bad++; $display("FAIL to1_flag: got %b expected 1", data_timeout); end
        n_cmp++; if (dist_of(1) !== (HOLD ? 0 : 511)) begin n_bad++; $display("FAIL to1_dist: got %0d expected %0d", dist_of(1), HOLD ? 0 : 511); end
    endtask

    task automatic test_dist400();
        bit ok1, ok2;
        int lat;
        wait_trig_pulse(2, 200, ok1);
        repeat (5) @(negedge clk);
        echo[2] = 1'b1;
        echo[3] = 1'b1;   // non-selected sensor activity must be ignored
        for (int i = 0; i < 3204; i++) begin
            @(negedge clk);
            if (i == 99) echo[3] = 1'b0;
        end
        echo[2] = 1'b0;
        wait_valid(20, lat, ok2);
        n_cmp++; if ((ok1 & ok2) !== 1'b1) begin n_bad++; $display("FAIL d400_seen: got %b expected 1", ok1 & ok2); end
        n_cmp++; if (dist_of(2) !== 400) begin n_bad++; $display("FAIL d400_dist: got %0d expected 400", dist_of(2)); end
        n_cmp++; if (data_id !== 2'd2) begin n_bad++; $display("FAIL d400_id: got %0d expected 2", data_id); end
        n_cmp++; if (data_timeout !== 1'b0) begin n_bad++; $display("FAIL d400_flag: got %b expected 0", data_timeout); end
    endtask

    task automatic test_saturation();
        bit ok;
        ping(3, 5, 4200, ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL sat_seen: got %b expected 1", ok); end
        n_cmp++; if (dist_of(3) !== 511) begin n_bad++; $display("FAIL sat_dist: got %0d expected 511", dist_of(3)); end
        n_cmp++; if (data_timeout !== 1'b0) begin n_bad++; $display("FAIL sat_flag: got %b expected 0", data_timeout); end
        n_cmp++; if (data_id !== 2'd3) begin n_bad++; $display("FAIL sat_id: got %0d expected 3", data_id); end
    endtask

    task automatic test_echo_held();
        bit ok;
        int cyc;
        wait_trig_pulse(0, 200, ok);
        @(negedge clk); echo[2] = 1'b1;
        wait_valid(5000, cyc, ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL held_s0_seen: got %b expected 1", ok); end
        n_cmp++; if (data_timeout !== 1'b1) begin n_bad++; $display("FAIL held_s0_flag: got %b expected 1", data_timeout); end
        n_cmp++; if (dist_of(0) !== (HOLD ? 14 : 511)) begin n_bad++; $display("FAIL held_s0_dist: got %0d expected %0d", dist_of(0), HOLD ? 14 : 511); end
        wait_trig_pulse(1, 200, ok);
        wait_valid(5000, cyc, ok);
        n_cmp++; if (data_id !== 2'd1) begin n_bad++; $display("FAIL held_s1_id: got %0d expected 1", data_id); end
        wait_trig_pulse(2, 200, ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL held_s2_trig: got %b expected 1", ok); end
        wait_valid(5000, cyc, ok);
        n_cmp++; if (cyc !== TO_CYC) begin n_bad++; $display("FAIL held_s2_cycles: got %0d expected %0d", cyc, TO_CYC); end
        n_cmp++; if (data_id !== 2'd2) begin n_bad++; $display("FAIL held_s2_id: got %0d expected 2", data_id); end
        n_cmp++; if (data_timeout !== 1'b1) begin n_bad++; $display("FAIL held_s2_flag: got %b expected 1", data_timeout); end
        n_cmp++; if (dist_of(2) !== (HOLD ? 400 : 511)) begin n_bad++; $display("FAIL held_s2_dist: got %0d expected %0d", dist_of(2), HOLD ? 400 : 511); end
        @(negedge clk); echo[2] = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit ok;
        ping(3, 2, 10, ok);
        n_cmp++; if (dist_of(3) !== 1) begin n_bad++; $display("FAIL short_dist3: got %0d expected 1", dist_of(3)); end
        ping(0, 2, 10, ok);
        ping(1, 2, 10, ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL short_s1_seen: got %b expected 1", ok); end
        wait_trig_pulse(2, 300, ok);
        @(negedge clk); echo[2] = 1'b1;
        repeat (50) @(negedge clk);
        reset_p = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (trig !== 4'b0000) begin n_bad++; $display("FAIL rst_mid_trig: got %b expected 0000", trig); end
        n_cmp++; if (dist_flat !== '0) begin n_bad++; $display("FAIL rst_mid_dist: got %h expected 0", dist_flat); end
        n_cmp++; if (data_id !== 2'd0) begin n_bad++; $display("FAIL rst_mid_id: got %0d expected 0", data_id); end
        @(negedge clk); reset_p = 1'b0; echo[2] = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (trig !== 4'b0001) begin n_bad++; $display("FAIL rst_reissue: got %b expected 0001", trig); end
        // Reset while a trigger is high drops it on the same edge
        @(negedge clk); reset_p = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (trig !== 4'b0000) begin n_bad++; $display("FAIL rst_trig_drop: got %b expected 0000", trig); end
        @(negedge clk); reset_p = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (trig !== 4'b0001) begin n_bad++; $display("FAIL rst_reissue2: got %b expected 0001", trig); end
    endtask

    task automatic test_enable_drop();
        bit ok, quiet, changed;
        int lat;
        ping(0, 2, 10, ok);
        n_cmp++; if (dist_of(0) !== 1) begin n_bad++; $display("FAIL en_s0_dist: got %0d expected 1", dist_of(0)); end
        ping(1, 2, 10, ok);
        ping(2, 2, 10, ok);
        wait_trig_pulse(3, 300, ok);
        @(negedge clk); echo[3] = 1'b1;
        repeat (40) @(negedge clk);
        enable = 1'b0;
        repeat (40) @(negedge clk);
        echo[3] = 1'b0;
        wait_valid(20, lat, ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL en_valid_seen: got %b expected 1", ok); end
        n_cmp++; if (dist_of(3) !== 9) begin n_bad++; $display("FAIL en_dist3: got %0d expected 9", dist_of(3)); end
        n_cmp++; if (data_id !== 2'd3) begin n_bad++; $display("FAIL en_id: got %0d expected 3", data_id); end
        repeat (30) @(posedge clk); #1;
        n_cmp++; if (data_id !== 2'd3) begin n_bad++; $display("FAIL en_id_in_gap: got %0d expected 3", data_id); end
        repeat (31) @(posedge clk); #1;
        n_cmp++; if (data_id !== 2'd0) begin n_bad++; $display("FAIL en_id_wrap: got %0d expected 0", data_id); end
        quiet = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            @(posedge clk); #1;
            if (trig !== 4'b0000 || data_valid !== 1'b0) quiet = 1'b0;
        end
        n_cmp++; if (quiet !== 1'b1) begin n_bad++; $display("FAIL en_idle_quiet: got %b expected 1", quiet); end
        @(negedge clk); enable = 1'b1;
        @(posedge clk); #1;
        changed = (trig === 4'b0001);
        n_cmp++; if (changed !== 1'b1) begin n_bad++; $display("FAIL en_restart: got %b expected 0001", trig); end
    endtask

    initial begin
        reset_p = 1'b1;
        enable  = 1'b0;
        echo    = '0;
        test_reset();
        test_trigger();
        test_measure();
        test_timeout();
        test_dist400();
        test_saturation();
        test_echo_held();
        test_reset_mid();
        test_enable_drop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
